// File: rtl/fir_interp16.sv
// Linear-interpolating 1:16 upsampler with valid/ready on both sides.
// Each accepted sample closes a 16-output ramp from the previous sample towards it.
module fir_interp16 #(
    parameter int DATA_WIDTH = 12,
    parameter int PHASE_BITS = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int ACC_WIDTH = DATA_WIDTH + PHASE_BITS + 1;
    localparam logic [PHASE_BITS-1:0] LAST_PHASE = {PHASE_BITS{1'b1}};
    localparam logic [PHASE_BITS-1:0] PHASE_ONE  = {{(PHASE_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                        state_r, state_nxt_s;
    logic signed [DATA_WIDTH-1:0]  cur_r, cur_nxt_s;
    logic signed [DATA_WIDTH:0]    delta_r, delta_nxt_s;
    logic signed [ACC_WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [PHASE_BITS-1:0]         phase_r, phase_nxt_s;
    logic signed [DATA_WIDTH-1:0]  dout_r, dout_nxt_s;
    logic                          oval_r, oval_nxt_s;

    logic                          load_s;
    logic                          out_fire_s;
    logic [DATA_WIDTH:0]           diff_s;
    logic [ACC_WIDTH-1:0]          load_acc_s;
    logic [ACC_WIDTH-1:0]          sum_s;

    assign in_ready   = !reset && ((state_r == IDLE) ||
                                   ((state_r == RUN) && (phase_r == LAST_PHASE) && out_ready));
    assign load_s     = in_valid && in_ready;
    assign out_fire_s = oval_r && out_ready;

    // Sign-extended difference and accumulator seed keep the full ramp range without overflow.
    assign diff_s     = {data_in[DATA_WIDTH-1], data_in} - {cur_r[DATA_WIDTH-1], cur_r};
    assign load_acc_s = {cur_r[DATA_WIDTH-1], cur_r, {PHASE_BITS{1'b0}}};
    assign sum_s      = acc_r + {{PHASE_BITS{delta_r[DATA_WIDTH]}}, delta_r};

    assign data_out   = dout_r;
    assign out_valid  = oval_r;

    // Next-state and datapath update; everything holds unless a handshake fires.
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        delta_nxt_s = delta_r;
        acc_nxt_s   = acc_r;
        phase_nxt_s = phase_r;
        dout_nxt_s  = dout_r;
        oval_nxt_s  = oval_r;
        if (load_s) begin
            delta_nxt_s = diff_s;
            acc_nxt_s   = load_acc_s;
            cur_nxt_s   = data_in;
            phase_nxt_s = {PHASE_BITS{1'b0}};
            dout_nxt_s  = cur_r;
            oval_nxt_s  = 1'b1;
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    oval_nxt_s = 1'b0;
                end
                RUN: begin
                    if (out_fire_s && (phase_r != LAST_PHASE)) begin
                        acc_nxt_s   = sum_s;
                        phase_nxt_s = phase_r + PHASE_ONE;
                        dout_nxt_s  = sum_s[DATA_WIDTH+PHASE_BITS-1:PHASE_BITS];
                    end else if (out_fire_s) begin
                        oval_nxt_s  = 1'b0;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    oval_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cur_r   <= '0;
            delta_r <= '0;
            acc_r   <= '0;
            phase_r <= '0;
            dout_r  <= '0;
            oval_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cur_r   <= cur_nxt_s;
            delta_r <= delta_nxt_s;
            acc_r   <= acc_nxt_s;
            phase_r <= phase_nxt_s;
            dout_r  <= dout_nxt_s;
            oval_r  <= oval_nxt_s;
        end
    end

endmodule

// File: tb/tb_fir_interp16.sv
// Directed bench for fir_interp16: ramps, floor rounding, extremes, backpressure and mid-segment reset.
module tb_fir_interp16;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] data_in = 12'sd0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [11:0] data_out;
    logic               out_valid;
    logic               out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int in_q[$];
    int out_q[$];
    int rdy_q[$];
    int exp_q[$];

    fir_interp16 #(.DATA_WIDTH(12), .PHASE_BITS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("rst_in_ready", in_ready, 0);
        @(negedge clock);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_data_out", data_out, 0);
        reset = 1'b0;
        #1;
        check_val("rel_in_ready", in_ready, 1);
        in_q.delete();
        out_q.delete();
        rdy_q.delete();
        exp_q.delete();
    endtask

    // Drives queued inputs and collects fired outputs until target outputs or budget cycles.
    task automatic run_seg(input int target, input int budget, input bit bp);
        int cyc = 0;
        bit stall = 1'b0;
        int held = 0;
        while (out_q.size() < target && cyc < budget) begin
            @(negedge clock);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (in_q.size() != 0);
            data_in   = (in_q.size() != 0) ? 12'(in_q[0]) : 12'sd0;
            #1;
            if (stall) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_hold", data_out, held);
            end
            stall = out_valid && !out_ready;
            held  = data_out;
            if (out_valid && out_ready) begin
                out_q.push_back(int'(data_out));
                rdy_q.push_back(int'(in_ready));
            end
            if (in_valid && in_ready) begin
                if (out_valid)
                    check_val("in_on_last", (out_ready && (out_q.size() % 16 == 0)) ? 1 : 0, 1);
                void'(in_q.pop_front());
            end
            cyc++;
        end
        check_val("seg_count", out_q.size(), target);
    endtask

    task automatic idle_check();
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("idle_out_valid", out_valid, 0);
        check_val("idle_in_ready", in_ready, 1);
    endtask

    task automatic cmp_outs(input string tag);
        check_val({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check_val(tag, out_q[i], exp_q[i]);
    endtask

    initial begin
        // Ramps 0 -> 0 -> 160 -> -160 at full rate.
        do_reset();
        in_q = '{0, 160, -160};
        run_seg(48, 200, 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(0);
        for (int k = 0; k < 16; k++) exp_q.push_back(10 * k);
        for (int k = 0; k < 16; k++) exp_q.push_back(160 - 20 * k);
        cmp_outs("ramp");
        for (int i = 0; i < rdy_q.size(); i++)
            check_val("rdy_last", rdy_q[i], (i % 16 == 15) ? 1 : 0);
        idle_check();

        // Floor: 0 -> 1 gives all zeros.
        do_reset();
        in_q = '{1};
        run_seg(16, 100, 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(0);
        cmp_outs("floor_up");
        idle_check();

        // Floor: 0 -> -1 gives 0 then -1s.
        do_reset();
        in_q = '{-1};
        run_seg(16, 100, 1'b0);
        exp_q.push_back(0);
        for (int k = 1; k < 16; k++) exp_q.push_back(-1);
        cmp_outs("floor_dn");
        idle_check();

        // Full-scale swings.
        do_reset();
        in_q = '{2047, -2048, 2047};
        run_seg(48, 200, 1'b0);
        if (out_q.size() == 48) begin
            check_val("ext_k15_up0", out_q[15], 1919);
            check_val("ext_k0_dn", out_q[16], 2047);
            check_val("ext_k8_dn", out_q[24], -1);
            check_val("ext_k15_dn", out_q[31], -1793);
            check_val("ext_k0_up", out_q[32], -2048);
            check_val("ext_k8_up", out_q[40], -1);
            check_val("ext_k15_up", out_q[47], 1791);
        end
        idle_check();

        // Random backpressure must not change the sequence.
        do_reset();
        in_q = '{0, 160};
        run_seg(32, 600, 1'b1);
        for (int k = 0; k < 16; k++) exp_q.push_back(0);
        for (int k = 0; k < 16; k++) exp_q.push_back(10 * k);
        cmp_outs("bp");
        idle_check();

        // Reset at phase 7 of 0 -> 160, then a fresh ramp from 0 to 32.
        do_reset();
        in_q = '{0, 160};
        run_seg(23, 200, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("pre_rst_data", data_out, 70);
        check_val("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check_val("async_out_valid", out_valid, 0);
        check_val("async_in_ready", in_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        in_q.delete();
        out_q.delete();
        rdy_q.delete();
        exp_q.delete();
        in_q = '{32};
        run_seg(16, 100, 1'b0);
        for (int k = 0; k < 16; k++) exp_q.push_back(2 * k);
        cmp_outs("post_rst");
        idle_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_interp16.md
# fir_interp16

Linear-interpolating upsampler for the DSP/PLL datapath: the expansion-side counterpart of the 16-sample moving-average decimation stage. It takes one signed 12-bit sample per input handshake and emits 2^PHASE_BITS (16) output samples that ramp linearly from the previous sample towards the new one. Both sides use valid/ready flow control, so it can feed a DAC or NCO path running at 16x the input sample rate.

## Interface
- DATA_WIDTH, 12: sample width, two's complement, input and output.
- PHASE_BITS, 4: log2 of the interpolation factor L; L = 16.
- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- data_in  in  DATA_WIDTH  input sample, signed.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block accepts data_in this cycle (combinational).
- data_out  out  DATA_WIDTH  interpolated output sample, signed, registered.
- out_valid  out  1  data_out valid, registered.
- out_ready  in  1  downstream accepts data_out this cycle.

## Operation
- Internal state: cur (DATA_WIDTH, last accepted sample), delta (DATA_WIDTH+1 signed), acc (DATA_WIDTH+PHASE_BITS+1 signed), phase (PHASE_BITS), state in {IDLE, RUN}.
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- in_ready = !reset & ((state==IDLE) | (state==RUN & phase==L-1 & out_ready)).
- On input fire (from IDLE, or from RUN at the last phase): delta <= data_in - cur; acc <= cur <<< PHASE_BITS; cur <= data_in; phase <= 0; data_out <= cur (old value); out_valid <= 1; state <= RUN.
- RUN, output fire, phase < L-1: acc <= acc + delta; phase <= phase + 1; data_out <= (acc + delta) >>> PHASE_BITS.
- RUN, output fire, phase == L-1, no input fire: out_valid <= 0; state <= IDLE.
- RUN, no output fire: all registers hold, including data_out. Data must not change while out_valid & !out_ready.
- Output k of a segment (k = 0..L-1) = prev + floor((new - prev)*k / L), using arithmetic shift (floor, no rounding). It always lies between prev and new, so no saturation logic exists or is needed.
- The segment from prev to new ends at phase L-1. Value new itself appears as phase 0 of the next segment, so output lags input by one segment.
- Width rules: delta is DATA_WIDTH+1 bits and holds the full range -4095..4095. acc is DATA_WIDTH+PHASE_BITS+1 bits and must not overflow at any k.

## Timing
- Reset values: data_out = 0, out_valid = 0, cur = 0, delta = 0, acc = 0, phase = 0, state = IDLE. in_ready is 0 while reset is high and 1 in the first cycle after release.
- Latency: out_valid rises on the edge that accepts an input. The first output of a segment is the previous sample.
- Throughput: with in_valid and out_ready held high, exactly L outputs per input with no bubble. The last-phase output fire and the next input fire occur on the same edge.
- Simultaneous events: a last-phase output fire plus an input fire loads the new segment. out_valid stays 1.
- Backpressure: out_ready low at phase L-1 forces in_ready low. An input offered then waits and is not lost.
- Input while IDLE is accepted immediately. in_valid deasserted at the segment end returns the block to IDLE after the last output.
- Reset mid-segment: out_valid drops asynchronously, the rest of the segment is discarded, and cur returns to 0. The next segment ramps from 0.
- phase never wraps on its own. It advances only on output fire and resets only on input fire.

## Test plan
- Reset, then accept 0, then accept 160, out_ready = 1 throughout: first 16 outputs are 0; next 16 are 0, 10, 20, ..., 150; in_ready is high exactly on the 16th output of each segment.
- After 160, accept -160: outputs 160, 140, 120, ..., -140 (delta = -320, step -20).
- Floor behaviour: segment 0 -> 1 gives sixteen 0s. Segment 0 -> -1 gives 0 followed by fifteen -1s.
- Extremes: segment 2047 -> -2048 gives k=0 output 2047 and k=15 output -1793, with no wrap. Segment -2048 -> 2047 gives k=15 output 1791.
- Backpressure: toggle out_ready pseudo-randomly during a 0 -> 160 segment. The output sequence is unchanged and data_out is stable while stalled. in_valid held high from mid-segment is accepted only on the last-phase fire.
- Reset asserted at phase 7 of a 0 -> 160 segment: out_valid goes 0 immediately. After release, accepting 32 yields 0, 2, 4, ..., 30.
